tt_pin_sequencer: RTL
=====================

// Module: tt_pin_sequencer
// PURPOSE
//  Host-side driver for a tt_um_* user project's pin interface (ui_in/uio_in/ena/rst_n in, uo_out/uio_out/uio_oe back).
//  Executes a valid/ready command stream, driving DUT inputs, timing waits and reset pulses.
//  Samples DUT outputs on request and returns them on a valid/ready response channel.
//  Sits between an on-chip test controller (or the cocotb bench) and the user project instance.
// PARAMETERS
//  RST_CYCLES     10  cycles dut_rst_n is held low by PULSE_RST (>=1)
//  SETTLE_CYCLES  2   cycles between CAPTURE accept and sampling of DUT outputs (>=0)
// PORTS
//  clk          in   1   clock; all logic on rising edge
//  rst          in   1   synchronous active-high reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   sequencer can accept a command
//  cmd_op       in   3   0 NOP, 1 SET_UI, 2 SET_UIO, 3 WAIT, 4 PULSE_RST, 5 CAPTURE, 6 SET_ENA, 7 illegal
//  cmd_data     in   8   operand (value / cycle count / ena in bit 0)
//  rsp_valid    out  1   capture result present
//  rsp_ready    in   1   consumer accepts result
//  rsp_data     out  24  {uio_oe, uio_out, uo_out} as sampled
//  illegal_op   out  1   sticky: op 7 was accepted; cleared only by rst
//  dut_ui_in    out  8   to DUT ui_in
//  dut_uio_in   out  8   to DUT uio_in
//  dut_ena      out  1   to DUT ena
//  dut_rst_n    out  1   to DUT rst_n (active low)
//  dut_uo_out   in   8   from DUT uo_out
//  dut_uio_out  in   8   from DUT uio_out
//  dut_uio_oe   in   8   from DUT uio_oe
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; dut_ui_in=0, dut_uio_in=0, dut_ena=0, dut_rst_n=0 (DUT held in reset
//   until first PULSE_RST completes), rsp_valid=0, rsp_data=0, illegal_op=0, counters=0. Reset mid-op aborts it.
//  States: IDLE, WAIT, RSTP, SETTLE, RESP. cmd_ready = (state==IDLE), registered-equivalent, no comb path from cmd_valid.
//  Accept = cmd_valid & cmd_ready. All effects appear on outputs the cycle after the accepting edge.
//  NOP: stay IDLE. SET_UI/SET_UIO: register cmd_data to dut_ui_in/dut_uio_in, stay IDLE (back-to-back accepts allowed).
//  SET_ENA: dut_ena <= cmd_data[0], stay IDLE. illegal (7): set illegal_op, treat as NOP.
//  WAIT n: n=0 -> behaves as NOP; n>=1 -> WAIT state, cmd_ready low exactly n cycles, then IDLE.
//  PULSE_RST: dut_rst_n low exactly RST_CYCLES cycles (incl. if already low), then 1; cmd_ready
//   reasserts in the same cycle dut_rst_n returns high. Other DUT drives unchanged.
//  CAPTURE: SETTLE for SETTLE_CYCLES cycles (0 -> sample on the next edge), then sample DUT outputs into
//   rsp_data and enter RESP with rsp_valid=1. Latency accept->rsp_valid = SETTLE_CYCLES+1 cycles.
//  RESP: rsp_valid and rsp_data stable until rsp_valid&rsp_ready; then IDLE (cmd_ready=1 next cycle).
//   No new command accepted while a response is pending.
//  Counters 8-bit (WAIT) and sized for max(RST_CYCLES,SETTLE_CYCLES); no wrap, count down to terminal.
//  DUT inputs never change except on SET_*/PULSE_RST/rst; all outputs are registered.
// TESTING
//  1 rst -> dut_rst_n=0, dut_ena=0, dut_ui_in=0, cmd_ready=1, rsp_valid=0, illegal_op=0.
//  2 PULSE_RST then SET_ENA 1 -> dut_rst_n low 10 cycles then 1; cmd_ready low 10 cycles; dut_ena=1 after.
//  3 SET_UI 0xA5, SET_UIO 0x3C back-to-back -> dut_ui_in=0xA5, dut_uio_in=0x3C, cmd_ready never drops.
//  4 DUT stub uo_out=ui_in+1; SET_UI 0x41, CAPTURE -> rsp_valid 3 cycles after accept, rsp_data[7:0]=0x42;
//    rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0 throughout.
//  5 WAIT 0 -> next cmd accepted next cycle; WAIT 255 -> cmd_ready low exactly 255 cycles.
//  6 op 7 -> illegal_op=1, state unchanged; rst asserted during WAIT 100 -> IDLE, all outputs at reset values.

Source files
------------

// File: rtl/tt_pin_sequencer.sv
// tt_pin_sequencer: executes a valid/ready command stream against a tt_um_* pin interface and returns captured outputs.
module tt_pin_sequencer #(
  parameter int RST_CYCLES = 10,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [23:0] rsp_data,
  output logic        illegal_op,
  output logic [7:0]  dut_ui_in,
  output logic [7:0]  dut_uio_in,
  output logic        dut_ena,
  output logic        dut_rst_n,
  input  logic [7:0]  dut_uo_out,
  input  logic [7:0]  dut_uio_out,
  input  logic [7:0]  dut_uio_oe
);
  localparam int MX = RST_CYCLES > SETTLE_CYCLES ? RST_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MX + 1) > 8 ? $clog2(MX + 1) : 8;
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RSTP, S_SETTLE, S_RESP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] ui_n, uio_n;
  logic ena_n, rst_n_n, ill_n;
  logic [23:0] data_n;
  logic done;
  assign cmd_ready = state == S_IDLE;
  assign rsp_valid = state == S_RESP;
  assign done = cnt == '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ui_n = dut_ui_in;
    uio_n = dut_uio_in;
    ena_n = dut_ena;
    rst_n_n = dut_rst_n;
    ill_n = illegal_op;
    data_n = rsp_data;
    case (state)
      S_IDLE: if (cmd_valid) begin
        case (cmd_op)
          3'd1: ui_n = cmd_data;
          3'd2: uio_n = cmd_data;
          3'd3: if (cmd_data != 8'd0) begin
            state_n = S_WAIT;
            cnt_n = CW'(cmd_data) - CW'(1);
          end
          3'd4: begin
            state_n = S_RSTP;
            rst_n_n = 1'b0;
            cnt_n = CW'(RST_CYCLES - 1);
          end
          3'd5: begin
            state_n = S_SETTLE;
            cnt_n = CW'(SETTLE_CYCLES);
          end
          3'd6: ena_n = cmd_data[0];
          3'd7: ill_n = 1'b1;
          default: ;
        endcase
      end
      S_WAIT: begin
        state_n = done ? S_IDLE : S_WAIT;
        cnt_n = done ? cnt : cnt - CW'(1);
      end
      S_RSTP: begin
        state_n = done ? S_IDLE : S_RSTP;
        rst_n_n = done;
        cnt_n = done ? cnt : cnt - CW'(1);
      end
      S_SETTLE: begin
        state_n = done ? S_RESP : S_SETTLE;
        data_n = done ? {dut_uio_oe, dut_uio_out, dut_uo_out} : rsp_data;
        cnt_n = done ? cnt : cnt - CW'(1);
      end
      S_RESP: state_n = rsp_ready ? S_IDLE : S_RESP;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      dut_ui_in <= '0;
      dut_uio_in <= '0;
      dut_ena <= 1'b0;
      dut_rst_n <= 1'b0;
      illegal_op <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dut_ui_in <= ui_n;
      dut_uio_in <= uio_n;
      dut_ena <= ena_n;
      dut_rst_n <= rst_n_n;
      illegal_op <= ill_n;
      rsp_data <= data_n;
    end
  end
endmodule
